// File: rtl/mem_port_arbiter_if.sv
// Bus bundle between the two pipeline requesters (IF, D), the shared RAM and mem_port_arbiter.
// The slave modport is the arbiter's view. The master modport is the requester/RAM side.
interface mem_port_arbiter_if #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32
);
  logic                  if_req;
  logic [ADDR_WIDTH-1:0] if_addr;
  logic                  if_gnt;
  logic                  if_rvalid;
  logic [DATA_WIDTH-1:0] if_rdata;

  logic                  d_req;
  logic                  d_we;
  logic [ADDR_WIDTH-1:0] d_addr;
  logic [DATA_WIDTH-1:0] d_wdata;
  logic                  d_gnt;
  logic                  d_rvalid;
  logic [DATA_WIDTH-1:0] d_rdata;

  logic                  mem_write;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic [DATA_WIDTH-1:0] mem_rdata;

  modport slave (
    input  if_req, if_addr,
    output if_gnt, if_rvalid, if_rdata,
    input  d_req, d_we, d_addr, d_wdata,
    output d_gnt, d_rvalid, d_rdata,
    output mem_write, mem_addr, mem_wdata,
    input  mem_rdata
  );

  modport master (
    output if_req, if_addr,
    input  if_gnt, if_rvalid, if_rdata,
    output d_req, d_we, d_addr, d_wdata,
    input  d_gnt, d_rvalid, d_rdata,
    input  mem_write, mem_addr, mem_wdata,
    output mem_rdata
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Single-port RAM arbiter for the IF and D ports. It grants one port per cycle combinationally and registers the read data.
// Optional performance counters are enabled by defining MEM_ARB_PERF_EN.
module mem_port_arbiter #(
  parameter int ADDR_WIDTH  = 8,
  parameter int DATA_WIDTH  = 32,
  parameter int ROUND_ROBIN = 1,
  parameter int MAX_WAIT    = 4
) (
  input  logic                clk,
  input  logic                rst,
  mem_port_arbiter_if.slave   bus
`ifdef MEM_ARB_PERF_EN
  ,
  output logic [31:0]         conflict_cnt,
  output logic [31:0]         if_stall_cnt
`endif
);

  typedef enum logic {
    GNT_IF = 1'b0,
    GNT_D  = 1'b1
  } port_e;

  localparam logic [3:0] MAX_WAIT_C = 4'(MAX_WAIT);

  port_e                 last_gnt_q, last_gnt_d;
  logic [3:0]            wait_cnt_q, wait_cnt_d;
  logic                  if_rvalid_q, if_rvalid_d;
  logic [DATA_WIDTH-1:0] if_rdata_q, if_rdata_d;
  logic                  d_rvalid_q, d_rvalid_d;
  logic [DATA_WIDTH-1:0] d_rdata_q, d_rdata_d;

  logic gnt_if;
  logic gnt_d;
  logic tie_to_if;

  // The tie-break rule is chosen at elaboration time. Only the selected rule produces logic.
  generate
    if (ROUND_ROBIN != 0) begin : g_round_robin
      assign tie_to_if = (last_gnt_q == GNT_D);
    end else begin : g_fixed_priority
      assign tie_to_if = (wait_cnt_q == MAX_WAIT_C);
    end
  endgenerate

  // Grants depend only on requests and state. mem_rdata never feeds them.
  always_comb begin
    gnt_if = 1'b0;
    gnt_d  = 1'b0;
    if (!rst) begin
      if (bus.if_req && bus.d_req) begin
        gnt_if = tie_to_if;
        gnt_d  = !tie_to_if;
      end else if (bus.if_req) begin
        gnt_if = 1'b1;
      end else if (bus.d_req) begin
        gnt_d = 1'b1;
      end
    end
  end

  assign bus.if_gnt    = gnt_if;
  assign bus.d_gnt     = gnt_d;
  assign bus.mem_addr  = gnt_d ? bus.d_addr : bus.if_addr;
  assign bus.mem_wdata = bus.d_wdata;
  assign bus.mem_write = gnt_d & bus.d_we;

  always_comb begin
    last_gnt_d  = last_gnt_q;
    wait_cnt_d  = wait_cnt_q;
    if_rvalid_d = gnt_if;
    if_rdata_d  = if_rdata_q;
    d_rvalid_d  = gnt_d & ~bus.d_we;
    d_rdata_d   = d_rdata_q;

    if (gnt_if) begin
      last_gnt_d = GNT_IF;
      if_rdata_d = bus.mem_rdata;
    end else if (gnt_d) begin
      last_gnt_d = GNT_D;
      if (!bus.d_we) begin
        d_rdata_d = bus.mem_rdata;
      end
    end

    // Counts consecutive cycles in which IF was denied. The count saturates so that a forced IF grant stays pending.
    if (gnt_if || !bus.if_req) begin
      wait_cnt_d = 4'd0;
    end else if (wait_cnt_q != MAX_WAIT_C) begin
      wait_cnt_d = wait_cnt_q + 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last_gnt_q  <= GNT_IF;
      wait_cnt_q  <= 4'd0;
      if_rvalid_q <= 1'b0;
      if_rdata_q  <= '0;
      d_rvalid_q  <= 1'b0;
      d_rdata_q   <= '0;
    end else begin
      last_gnt_q  <= last_gnt_d;
      wait_cnt_q  <= wait_cnt_d;
      if_rvalid_q <= if_rvalid_d;
      if_rdata_q  <= if_rdata_d;
      d_rvalid_q  <= d_rvalid_d;
      d_rdata_q   <= d_rdata_d;
    end
  end

  assign bus.if_rvalid = if_rvalid_q;
  assign bus.if_rdata  = if_rdata_q;
  assign bus.d_rvalid  = d_rvalid_q;
  assign bus.d_rdata   = d_rdata_q;

`ifdef MEM_ARB_PERF_EN
  logic [31:0] conflict_cnt_q, conflict_cnt_d;
  logic [31:0] if_stall_cnt_q, if_stall_cnt_d;

  always_comb begin
    conflict_cnt_d = conflict_cnt_q;
    if_stall_cnt_d = if_stall_cnt_q;
    if (bus.if_req && bus.d_req && (conflict_cnt_q != 32'hFFFF_FFFF)) begin
      conflict_cnt_d = conflict_cnt_q + 32'd1;
    end
    if (bus.if_req && !gnt_if && (if_stall_cnt_q != 32'hFFFF_FFFF)) begin
      if_stall_cnt_d = if_stall_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      conflict_cnt_q <= 32'd0;
      if_stall_cnt_q <= 32'd0;
    end else begin
      conflict_cnt_q <= conflict_cnt_d;
      if_stall_cnt_q <= if_stall_cnt_d;
    end
  end

  assign conflict_cnt = conflict_cnt_q;
  assign if_stall_cnt = if_stall_cnt_q;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed testbench for mem_port_arbiter. It drives a round-robin instance and a fixed-priority instance, each backed by its own RAM model.
module tb_mem_port_arbiter;

  logic clk;
  logic rst;
  int   tests_run;
  int   fails;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  mem_port_arbiter_if #(.ADDR_WIDTH(8), .DATA_WIDTH(32)) rr_bus ();
  mem_port_arbiter_if #(.ADDR_WIDTH(8), .DATA_WIDTH(32)) fp_bus ();

`ifdef MEM_ARB_PERF_EN
  logic [31:0] rr_conflict_cnt, rr_if_stall_cnt;
  logic [31:0] fp_conflict_cnt, fp_if_stall_cnt;
`endif

  mem_port_arbiter #(.ADDR_WIDTH(8), .DATA_WIDTH(32), .ROUND_ROBIN(1), .MAX_WAIT(4)) u_rr (
    .clk (clk),
    .rst (rst),
    .bus (rr_bus)
`ifdef MEM_ARB_PERF_EN
    ,
    .conflict_cnt (rr_conflict_cnt),
    .if_stall_cnt (rr_if_stall_cnt)
`endif
  );

  mem_port_arbiter #(.ADDR_WIDTH(8), .DATA_WIDTH(32), .ROUND_ROBIN(0), .MAX_WAIT(4)) u_fp (
    .clk (clk),
    .rst (rst),
    .bus (fp_bus)
`ifdef MEM_ARB_PERF_EN
    ,
    .conflict_cnt (fp_conflict_cnt),
    .if_stall_cnt (fp_if_stall_cnt)
`endif
  );

  function automatic logic [31:0] init_word(input logic [7:0] a);
    return {8'hA5, a, ~a, a};
  endfunction

  // RAM models: async read, sync write, known contents loaded while rst is high.
  logic [31:0] ram_rr [256];
  logic [31:0] ram_fp [256];

  assign rr_bus.mem_rdata = ram_rr[rr_bus.mem_addr];
  assign fp_bus.mem_rdata = ram_fp[fp_bus.mem_addr];

  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 256; i++) begin
        ram_rr[i] <= init_word(8'(i));
        ram_fp[i] <= init_word(8'(i));
      end
    end else begin
      if (rr_bus.mem_write) ram_rr[rr_bus.mem_addr] <= rr_bus.mem_wdata;
      if (fp_bus.mem_write) ram_fp[fp_bus.mem_addr] <= fp_bus.mem_wdata;
    end
  end

  task automatic idle_inputs();
    rr_bus.if_req = 0; rr_bus.if_addr = 0; rr_bus.d_req = 0; rr_bus.d_we = 0;
    rr_bus.d_addr = 0; rr_bus.d_wdata = 0;
    fp_bus.if_req = 0; fp_bus.if_addr = 0; fp_bus.d_req = 0; fp_bus.d_we = 0;
    fp_bus.d_addr = 0; fp_bus.d_wdata = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1;
    idle_inputs();
    @(negedge clk);
    rst = 0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1;
    rr_bus.if_req = 1; rr_bus.d_req = 1; rr_bus.d_we = 1;
    #1;
    tests_run++;
    if ({rr_bus.if_gnt, rr_bus.d_gnt, rr_bus.mem_write} !== 3'b000) begin
      fails++;
      $display("FAIL reset_gnt: got if_gnt/d_gnt/mem_write=%b expected 000",
               {rr_bus.if_gnt, rr_bus.d_gnt, rr_bus.mem_write});
    end
    @(negedge clk);
    tests_run++;
    if ({rr_bus.if_rvalid, rr_bus.d_rvalid, fp_bus.if_rvalid, fp_bus.d_rvalid} !== 4'b0000) begin
      fails++;
      $display("FAIL reset_rvalid: got %b expected 0000",
               {rr_bus.if_rvalid, rr_bus.d_rvalid, fp_bus.if_rvalid, fp_bus.d_rvalid});
    end
    tests_run++;
    if (rr_bus.if_rdata !== 32'h0 || rr_bus.d_rdata !== 32'h0) begin
      fails++;
      $display("FAIL reset_rdata: got if_rdata=%h d_rdata=%h expected 0",
               rr_bus.if_rdata, rr_bus.d_rdata);
    end
    idle_inputs();
    rst = 0;
  endtask

  task automatic test_write_read();
    @(negedge clk);
    rr_bus.d_req = 1; rr_bus.d_we = 1; rr_bus.d_addr = 8'h10; rr_bus.d_wdata = 32'hDEADBEEF;
    #1;
    tests_run++;
    if ({rr_bus.d_gnt, rr_bus.if_gnt, rr_bus.mem_write} !== 3'b101 || rr_bus.mem_addr !== 8'h10) begin
      fails++;
      $display("FAIL wr_cycle: got d_gnt/if_gnt/mem_write=%b mem_addr=%h expected 101 10",
               {rr_bus.d_gnt, rr_bus.if_gnt, rr_bus.mem_write}, rr_bus.mem_addr);
    end
    @(negedge clk);
    tests_run++;
    if (rr_bus.d_rvalid !== 1'b0) begin
      fails++;
      $display("FAIL wr_no_rvalid: got d_rvalid=%b expected 0", rr_bus.d_rvalid);
    end
    rr_bus.d_we = 0;
    #1;
    tests_run++;
    if ({rr_bus.d_gnt, rr_bus.mem_write} !== 2'b10) begin
      fails++;
      $display("FAIL rd_cycle: got d_gnt/mem_write=%b expected 10", {rr_bus.d_gnt, rr_bus.mem_write});
    end
    @(negedge clk);
    tests_run++;
    if (rr_bus.d_rvalid !== 1'b1 || rr_bus.d_rdata !== 32'hDEADBEEF) begin
      fails++;
      $display("FAIL rd_data: got d_rvalid=%b d_rdata=%h expected 1 deadbeef",
               rr_bus.d_rvalid, rr_bus.d_rdata);
    end
    idle_inputs();
    @(negedge clk);
    tests_run++;
    if (rr_bus.d_rvalid !== 1'b0 || rr_bus.d_rdata !== 32'hDEADBEEF) begin
      fails++;
      $display("FAIL rd_pulse: got d_rvalid=%b d_rdata=%h expected 0 deadbeef (held)",
               rr_bus.d_rvalid, rr_bus.d_rdata);
    end
  endtask

  task automatic test_round_robin();
    int if_cnt = 0;
    int d_cnt = 0;
    logic expect_if;
    do_reset();
    for (int i = 0; i <= 6; i++) begin
      @(negedge clk);
      if (i > 0) begin
        if (rr_bus.if_rvalid) begin
          if_cnt++;
          tests_run++;
          if (rr_bus.if_rdata !== init_word(8'h20)) begin
            fails++;
            $display("FAIL rr_if_rdata: got %h expected %h", rr_bus.if_rdata, init_word(8'h20));
          end
        end
        if (rr_bus.d_rvalid) begin
          d_cnt++;
          tests_run++;
          if (rr_bus.d_rdata !== init_word(8'h21)) begin
            fails++;
            $display("FAIL rr_d_rdata: got %h expected %h", rr_bus.d_rdata, init_word(8'h21));
          end
        end
      end
      if (i < 6) begin
        rr_bus.if_req = 1; rr_bus.if_addr = 8'h20;
        rr_bus.d_req = 1; rr_bus.d_we = 0; rr_bus.d_addr = 8'h21;
        #1;
        expect_if = (i % 2) == 1;
        tests_run++;
        if (rr_bus.if_gnt !== expect_if || rr_bus.d_gnt !== !expect_if ||
            rr_bus.mem_addr !== (expect_if ? 8'h20 : 8'h21)) begin
          fails++;
          $display("FAIL rr_gnt[%0d]: got if_gnt=%b d_gnt=%b mem_addr=%h expected if_gnt=%b",
                   i, rr_bus.if_gnt, rr_bus.d_gnt, rr_bus.mem_addr, expect_if);
        end
      end else begin
        idle_inputs();
      end
    end
    tests_run++;
    if (if_cnt != 3 || d_cnt != 3) begin
      fails++;
      $display("FAIL rr_rvalid_cnt: got if=%0d d=%0d expected 3 3", if_cnt, d_cnt);
    end
  endtask

  task automatic test_fixed_priority();
    logic [9:0] pattern = 10'b10_0001_0000;
    do_reset();
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      fp_bus.if_req = 1; fp_bus.if_addr = 8'h30;
      fp_bus.d_req = 1; fp_bus.d_we = 0; fp_bus.d_addr = 8'h31;
      #1;
      tests_run++;
      if (fp_bus.if_gnt !== pattern[i] || fp_bus.d_gnt !== !pattern[i]) begin
        fails++;
        $display("FAIL fp_gnt[%0d]: got if_gnt=%b d_gnt=%b expected if_gnt=%b",
                 i, fp_bus.if_gnt, fp_bus.d_gnt, pattern[i]);
      end
    end
    @(negedge clk);
    idle_inputs();
  endtask

  task automatic test_reset_midflight();
    @(negedge clk);
    rr_bus.d_req = 1; rr_bus.d_we = 0; rr_bus.d_addr = 8'h40;
    @(negedge clk);
    rst = 1;
    rr_bus.if_req = 1; rr_bus.if_addr = 8'h41; rr_bus.d_we = 1;
    #1;
    tests_run++;
    if ({rr_bus.if_gnt, rr_bus.d_gnt, rr_bus.mem_write} !== 3'b000) begin
      fails++;
      $display("FAIL midrst_gnt: got if_gnt/d_gnt/mem_write=%b expected 000",
               {rr_bus.if_gnt, rr_bus.d_gnt, rr_bus.mem_write});
    end
    @(negedge clk);
    rst = 0;
    tests_run++;
    if ({rr_bus.if_rvalid, rr_bus.d_rvalid} !== 2'b00) begin
      fails++;
      $display("FAIL midrst_rvalid: got %b expected 00", {rr_bus.if_rvalid, rr_bus.d_rvalid});
    end
    rr_bus.d_we = 0;
    #1;
    tests_run++;
    if (rr_bus.d_gnt !== 1'b1 || rr_bus.if_gnt !== 1'b0) begin
      fails++;
      $display("FAIL midrst_tie: got d_gnt=%b if_gnt=%b expected 1 0", rr_bus.d_gnt, rr_bus.if_gnt);
    end
    @(negedge clk);
    idle_inputs();
  endtask

  task automatic test_hazard();
    @(negedge clk);
    rr_bus.d_req = 1; rr_bus.d_we = 1; rr_bus.d_addr = 8'h05; rr_bus.d_wdata = 32'h0000_1234;
    @(negedge clk);
    idle_inputs();
    rr_bus.if_req = 1; rr_bus.if_addr = 8'h05;
    #1;
    tests_run++;
    if (rr_bus.if_gnt !== 1'b1) begin
      fails++;
      $display("FAIL hazard_gnt: got if_gnt=%b expected 1", rr_bus.if_gnt);
    end
    @(negedge clk);
    tests_run++;
    if (rr_bus.if_rvalid !== 1'b1 || rr_bus.if_rdata !== 32'h0000_1234) begin
      fails++;
      $display("FAIL hazard_data: got if_rvalid=%b if_rdata=%h expected 1 00001234",
               rr_bus.if_rvalid, rr_bus.if_rdata);
    end
    idle_inputs();
  endtask

  task automatic test_back_to_back();
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      if (i > 1) begin
        tests_run++;
        if (rr_bus.if_rvalid !== 1'b1 || rr_bus.if_rdata !== init_word(8'(i - 1))) begin
          fails++;
          $display("FAIL b2b[%0d]: got if_rvalid=%b if_rdata=%h expected 1 %h",
                   i - 1, rr_bus.if_rvalid, rr_bus.if_rdata, init_word(8'(i - 1)));
        end
      end
      if (i < 4) begin
        rr_bus.if_req = 1; rr_bus.if_addr = 8'(i);
      end else begin
        idle_inputs();
      end
    end
  endtask

`ifdef MEM_ARB_PERF_EN
  task automatic test_perf();
    int denied = 0;
    do_reset();
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      rr_bus.if_req = 1; rr_bus.if_addr = 8'h50;
      rr_bus.d_req = 1; rr_bus.d_we = 0; rr_bus.d_addr = 8'h51;
      #1;
      if (!rr_bus.if_gnt) denied++;
    end
    @(negedge clk);
    idle_inputs();
    tests_run++;
    if (rr_conflict_cnt !== 32'd7) begin
      fails++;
      $display("FAIL perf_conflict: got %0d expected 7", rr_conflict_cnt);
    end
    tests_run++;
    if (rr_if_stall_cnt !== 32'd4 || denied != 4) begin
      fails++;
      $display("FAIL perf_stall: got cnt=%0d bench_denied=%0d expected 4", rr_if_stall_cnt, denied);
    end
  endtask
`endif

  initial begin
    tests_run = 0;
    fails = 0;
    rst = 1;
    idle_inputs();
    test_reset();
    test_write_read();
    test_round_robin();
    test_fixed_priority();
    test_reset_midflight();
    test_hazard();
    test_back_to_back();
`ifdef MEM_ARB_PERF_EN
    test_perf();
`endif
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule
